// File: rtl/det_bareiss_sequencer.sv
// rtl/det_bareiss_sequencer.sv - Bareiss determinant sequencer driving one shared mul-sub-div ALU.
// Optional DET_CYCLE_COUNT_EN adds the cyc_count busy-cycle counter output.
module det_bareiss_sequencer #(
    parameter int N  = 8,
    parameter int EW = 4,
    parameter int DW = 32
) (
    input  logic              board_clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              ack,
    input  logic [N*N*EW-1:0] mat_flat,
    output logic              busy,
    output logic              done,
    output logic              singular,
    output logic [DW-1:0]     det,
    output logic              alu_req,
    output logic [DW-1:0]     alu_a,
    output logic [DW-1:0]     alu_b,
    output logic [DW-1:0]     alu_c,
    output logic [DW-1:0]     alu_d,
    output logic [DW-1:0]     alu_div,
    input  logic              alu_ack,
`ifdef DET_CYCLE_COUNT_EN
    output logic [31:0]       cyc_count,
`endif
    input  logic [DW-1:0]     alu_result
);
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] LAST = KW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_PIVOT, S_SCAN, S_SWAP, S_ISSUE, S_WAIT, S_DONE
    } state_t;

    state_t        state;
    logic [DW-1:0] a [N][N];
    logic [KW-1:0] k, i, j, r;
    logic          neg;
    logic [DW-1:0] prev;

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            state    <= S_IDLE;
            for (int rr = 0; rr < N; rr++)
                for (int cc = 0; cc < N; cc++)
                    a[rr][cc] <= '0;
            k        <= '0;
            i        <= '0;
            j        <= '0;
            r        <= '0;
            neg      <= 1'b0;
            prev     <= DW'(1);
            busy     <= 1'b0;
            done     <= 1'b0;
            singular <= 1'b0;
            det      <= '0;
            alu_req  <= 1'b0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_c    <= '0;
            alu_d    <= '0;
            alu_div  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    for (int rr = 0; rr < N; rr++)
                        for (int cc = 0; cc < N; cc++)
                            a[rr][cc] <= DW'(mat_flat[(rr*N+cc)*EW +: EW]);
                    k     <= '0;
                    prev  <= DW'(1);
                    neg   <= 1'b0;
                    state <= S_PIVOT;
                end
                S_PIVOT: begin
                    if (a[k][k] != '0) begin
                        i     <= k + 1'b1;
                        j     <= k + 1'b1;
                        state <= S_ISSUE;
                    end else begin
                        r     <= k + 1'b1;
                        state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (a[r][k] != '0) begin
                        state <= S_SWAP;
                    end else if (r == LAST) begin
                        singular <= 1'b1;
                        det      <= '0;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        r <= r + 1'b1;
                    end
                end
                S_SWAP: begin
                    for (int cc = 0; cc < N; cc++) begin
                        a[k][cc] <= a[r][cc];
                        a[r][cc] <= a[k][cc];
                    end
                    neg   <= ~neg;
                    i     <= k + 1'b1;
                    j     <= k + 1'b1;
                    state <= S_ISSUE;
                end
                S_ISSUE: begin
                    alu_a   <= a[k][k];
                    alu_b   <= a[i][j];
                    alu_c   <= a[i][k];
                    alu_d   <= a[k][j];
                    alu_div <= prev;
                    alu_req <= 1'b1;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (alu_ack) begin
                        a[i][j] <= alu_result;
                        alu_req <= 1'b0;
                        if (j != LAST) begin
                            j     <= j + 1'b1;
                            state <= S_ISSUE;
                        end else begin
                            j <= k + 1'b1;
                            if (i != LAST) begin
                                i     <= i + 1'b1;
                                state <= S_ISSUE;
                            end else begin
                                prev <= a[k][k];
                                k    <= k + 1'b1;
                                if (k + 1'b1 == LAST) begin
                                    // The final update always lands in a[N-1][N-1], so take it straight from the ALU.
                                    det   <= neg ? -alu_result : alu_result;
                                    done  <= 1'b1;
                                    state <= S_DONE;
                                end else begin
                                    state <= S_PIVOT;
                                end
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (ack) begin
                        busy     <= 1'b0;
                        done     <= 1'b0;
                        singular <= 1'b0;
                        det      <= '0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DET_CYCLE_COUNT_EN
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset)
            cyc_count <= '0;
        else if (state == S_LOAD)
            cyc_count <= '0;
        else if (state inside {S_PIVOT, S_SCAN, S_SWAP, S_ISSUE, S_WAIT})
            cyc_count <= cyc_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_det_bareiss_sequencer.sv
// tb/tb_det_bareiss_sequencer.sv - directed bench for det_bareiss_sequencer with a delayed exact ALU model.
module tb_det_bareiss_sequencer;
    localparam int N  = 8;
    localparam int EW = 4;
    localparam int DW = 32;

    logic              board_clk = 1'b0;
    logic              Reset;
    logic              start;
    logic              ack;
    logic [N*N*EW-1:0] mat_flat;
    logic              busy, done, singular, alu_req;
    logic [DW-1:0]     det, alu_a, alu_b, alu_c, alu_d, alu_div;
    logic              alu_ack = 1'b0;
    logic [DW-1:0]     alu_result = '0;
`ifdef DET_CYCLE_COUNT_EN
    logic [31:0]       cyc_count;
`endif

    det_bareiss_sequencer #(.N(N), .EW(EW), .DW(DW)) dut (
        .board_clk (board_clk),
        .Reset     (Reset),
        .start     (start),
        .ack       (ack),
        .mat_flat  (mat_flat),
        .busy      (busy),
        .done      (done),
        .singular  (singular),
        .det       (det),
        .alu_req   (alu_req),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_c     (alu_c),
        .alu_d     (alu_d),
        .alu_div   (alu_div),
        .alu_ack   (alu_ack),
`ifdef DET_CYCLE_COUNT_EN
        .cyc_count (cyc_count),
`endif
        .alu_result(alu_result)
    );

    always #5 board_clk = ~board_clk;

    int tests = 0;
    int fails = 0;

    // ALU model state (written only by the model process)
    int           alu_delay = 1;
    int           inject_req = 0;
    int           injected = 0;
    int           txn = 0;
    int           stab_err = 0;
    int           len_err = 0;
    int           req_cycles = 0;
    logic         last_req = 1'b0;
    logic [159:0] held_ops = '0;

    always @(negedge board_clk) begin
        logic signed [DW-1:0] sa, sb, sc, sd, sdiv;
        alu_ack = 1'b0;
        if (Reset) begin
            req_cycles = 0;
        end else if (alu_req) begin
            req_cycles++;
            if (req_cycles == 1)
                held_ops = {alu_a, alu_b, alu_c, alu_d, alu_div};
            else if (held_ops !== {alu_a, alu_b, alu_c, alu_d, alu_div})
                stab_err++;
            if (req_cycles >= alu_delay) begin
                if (req_cycles != alu_delay) len_err++;
                sa = alu_a; sb = alu_b; sc = alu_c; sd = alu_d; sdiv = alu_div;
                alu_result = (sa * sb - sc * sd) / sdiv;
                alu_ack = 1'b1;
                txn++;
                req_cycles = 0;
            end
        end else if (inject_req != 0 && injected == 0 && last_req) begin
            alu_result = 32'hDEADBEEF;
            alu_ack = 1'b1;
            injected++;
        end
        last_req = alu_req;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_ident(input logic [3:0] v);
        mat_flat = '0;
        for (int d = 0; d < N; d++) mat_flat[(d*N+d)*EW +: EW] = v;
    endtask

    task automatic run(output int cyc);
        start = 1'b1;
        @(negedge board_clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 5000) begin
            if (busy) cyc++;
            @(negedge board_clk);
        end
    endtask

    task automatic release_done();
        ack = 1'b1;
        @(negedge board_clk);
        ack = 1'b0;
        check("idle_done", {31'd0, done}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    int cyc, t0, s0, l0, w;

    initial begin
        Reset = 1'b1; start = 1'b0; ack = 1'b0; mat_flat = '0;
        repeat (2) @(negedge board_clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_singular", {31'd0, singular}, 32'd0);
        check("rst_det", det, 32'd0);
        check("rst_alu_req", {31'd0, alu_req}, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        Reset = 1'b0;
        @(negedge board_clk);

        // identity, D=1
        set_ident(4'd1);
        t0 = txn;
        run(cyc);
        check("id_done", {31'd0, done}, 32'd1);
        check("id_det", det, 32'h00000001);
        check("id_singular", {31'd0, singular}, 32'd0);
        check("id_cycles", cyc, 32'd288);
        check("id_txn", txn - t0, 32'd140);
        release_done();

        // diagonal 2s
        set_ident(4'd2);
        run(cyc);
        check("diag_det", det, 32'h00000100);
        check("diag_cycles", cyc, 32'd288);
        release_done();

        // identity with rows 0 and 1 exchanged: one scan + one swap
        set_ident(4'd1);
        mat_flat[0 +: EW] = 4'd0;
        mat_flat[(1*N+1)*EW +: EW] = 4'd0;
        mat_flat[(0*N+1)*EW +: EW] = 4'd1;
        mat_flat[(1*N+0)*EW +: EW] = 4'd1;
        run(cyc);
        check("swap_det", det, 32'hFFFFFFFF);
        check("swap_singular", {31'd0, singular}, 32'd0);
        check("swap_cycles", cyc, 32'd290);
        release_done();

        // column 3 all zero
        set_ident(4'd1);
        mat_flat[(3*N+3)*EW +: EW] = 4'd0;
        run(cyc);
        check("sing_done", {31'd0, done}, 32'd1);
        check("sing_flag", {31'd0, singular}, 32'd1);
        check("sing_det", det, 32'd0);
        check("sing_cycles", cyc, 32'd229);
        repeat (10) @(negedge board_clk);
        check("sing_hold_done", {31'd0, done}, 32'd1);
        check("sing_hold_flag", {31'd0, singular}, 32'd1);
        ack = 1'b1; start = 1'b1;
        @(negedge board_clk);
        ack = 1'b0; start = 1'b0;
        check("ackstart_done", {31'd0, done}, 32'd0);
        check("ackstart_singular", {31'd0, singular}, 32'd0);
        check("ackstart_busy", {31'd0, busy}, 32'd0);
        @(negedge board_clk);
        check("start_dropped", {31'd0, busy}, 32'd0);

        // D=5 with a stray ack in ISSUE; mat_flat changed after LOAD must not matter
        alu_delay = 5;
        inject_req = 1;
        set_ident(4'd2);
        t0 = txn; s0 = stab_err; l0 = len_err;
        start = 1'b1;
        @(negedge board_clk);
        start = 1'b0;
        @(negedge board_clk);
        mat_flat = '0;
        cyc = 1;
        while (!done && cyc < 5000) begin
            if (busy) cyc++;
            @(negedge board_clk);
        end
        inject_req = 0;
        check("d5_det", det, 32'h00000100);
        check("d5_cycles", cyc, 32'd848);
        check("d5_txn", txn - t0, 32'd140);
        check("d5_stable", stab_err - s0, 32'd0);
        check("d5_req_len", len_err - l0, 32'd0);
        check("d5_injected", injected, 32'd1);
        release_done();

        // reset during WAIT
        set_ident(4'd2);
        start = 1'b1;
        @(negedge board_clk);
        start = 1'b0;
        w = 0;
        while (!alu_req && w < 100) begin
            @(negedge board_clk);
            w++;
        end
        check("rw_req_seen", {31'd0, alu_req}, 32'd1);
        #2 Reset = 1'b1;
        #1;
        check("rw_alu_req", {31'd0, alu_req}, 32'd0);
        check("rw_busy", {31'd0, busy}, 32'd0);
        @(negedge board_clk);
        #1 Reset = 1'b0;
        @(negedge board_clk);
        alu_delay = 1;
        run(cyc);
        check("rw_det", det, 32'h00000100);
        check("rw_cycles", cyc, 32'd288);
        release_done();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
